// File: rtl/opa.sv
// Output peripheral adapter: serializes a 16-bit bus word as two 10-bit frames
// (start, 8 data LSB first, stop) on a txd/txc strobed link, acking on completion.
module opa (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cyc_i,
  input  logic [15:0] dat_i,
  output logic        ack_o,
  output logic        txd_o,
  output logic        txc_o
);

  typedef enum logic [1:0] {StIdle, StSend, StAck} state_e;

  state_e      state_q;
  logic [4:0]  idx_q;
  logic        phase_q;
  logic [15:0] sreg_q;
  logic        live_q;

  logic [4:0]  idx_nx;
  logic        data_nx;
  logic        bit_nx;

  // Indices 10 (start) is the only framing 0; 9 and 19 are stop bits.
  always_comb begin
    idx_nx  = idx_q + 5'd1;
    data_nx = (idx_nx >= 5'd1 && idx_nx <= 5'd8) || (idx_nx >= 5'd11 && idx_nx <= 5'd18);
    bit_nx  = data_nx ? sreg_q[0] : (idx_nx != 5'd10);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      phase_q <= 1'b0;
      sreg_q  <= '0;
      live_q  <= 1'b0;
      ack_o   <= 1'b0;
      txd_o   <= 1'b1;
      txc_o   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_o <= 1'b0;
          txd_o <= 1'b1;
          txc_o <= 1'b0;
          if (cyc_i) begin
            sreg_q  <= dat_i;
            idx_q   <= '0;
            phase_q <= 1'b0;
            live_q  <= 1'b1;
            txd_o   <= 1'b0;
            txc_o   <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          // A dropped request is remembered so the word finishes without an ack.
          if (!cyc_i) live_q <= 1'b0;
          if (!phase_q) begin
            phase_q <= 1'b1;
            txc_o   <= 1'b0;
          end else if (idx_q == 5'd19) begin
            state_q <= StAck;
            ack_o   <= live_q & cyc_i;
            txd_o   <= 1'b1;
            txc_o   <= 1'b0;
            idx_q   <= '0;
            phase_q <= 1'b0;
          end else begin
            idx_q   <= idx_nx;
            phase_q <= 1'b0;
            txd_o   <= bit_nx;
            txc_o   <= 1'b1;
            if (data_nx) sreg_q <= {1'b0, sreg_q[15:1]};
          end
        end
        StAck: begin
          ack_o   <= 1'b0;
          txd_o   <= 1'b1;
          txc_o   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_opa.sv
// Directed self-checking bench for opa: idle hold, framing of two words,
// back-to-back throughput, mid-word cyc drop and mid-frame reset.
module tb_opa;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cyc_i = 1'b0;
  logic [15:0] dat_i = '0;
  logic        ack_o;
  logic        txd_o;
  logic        txc_o;

  int n_assert = 0;
  int n_fail   = 0;

  opa dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .cyc_i  (cyc_i),
    .dat_i  (dat_i),
    .ack_o  (ack_o),
    .txd_o  (txd_o),
    .txc_o  (txc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({31'd0, txd_o}, 32'd1, {tag, " txd"});
    chk({31'd0, txc_o}, 32'd0, {tag, " txc"});
    chk({31'd0, ack_o}, 32'd0, {tag, " ack"});
  endtask

  // Called in cycle 1 after the accepting edge; returns in cycle 41.
  task automatic run_word(input logic [19:0] eb, input logic exp_ack, input int drop_at,
                          input string tag);
    for (int n = 0; n < 20; n++) begin
      if (2 * n + 1 == drop_at) cyc_i = 1'b0;
      chk({31'd0, txc_o}, 32'd1, $sformatf("%s strobe bit%0d", tag, n));
      chk({31'd0, txd_o}, {31'd0, eb[n]}, $sformatf("%s data bit%0d", tag, n));
      chk({31'd0, ack_o}, 32'd0, $sformatf("%s early ack bit%0d", tag, n));
      tick();
      if (2 * n + 2 == drop_at) cyc_i = 1'b0;
      chk({31'd0, txc_o}, 32'd0, $sformatf("%s gap bit%0d", tag, n));
      chk({31'd0, txd_o}, {31'd0, eb[n]}, $sformatf("%s hold bit%0d", tag, n));
      tick();
    end
    chk({31'd0, ack_o}, {31'd0, exp_ack}, {tag, " ack c41"});
    chk({31'd0, txd_o}, 32'd1, {tag, " txd c41"});
    chk({31'd0, txc_o}, 32'd0, {tag, " txc c41"});
  endtask

  // Frames laid out as {stop, hi, start, stop, lo, start}; bit 0 goes first.
  logic [19:0] eb_2211 = 20'b1_00100010_0_1_00010001_0;
  logic [19:0] eb_4433 = 20'b1_01000100_0_1_00110011_0;
  logic [19:0] eb_00ff = 20'b1_00000000_0_1_11111111_0;

  initial begin
    // Reset, then idle for 100 cycles.
    tick();
    reset_i = 1'b0;
    chk_idle("reset");
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_idle("idle100");
    end

    // 0x2211 then 0x4433 back-to-back with cyc held.
    cyc_i = 1'b1;
    dat_i = 16'h2211;
    tick();
    run_word(eb_2211, 1'b1, 0, "w2211");
    tick();
    dat_i = 16'h4433;
    chk_idle("c42 after w2211");
    tick();
    run_word(eb_4433, 1'b1, 0, "w4433");
    tick();
    cyc_i = 1'b0;
    chk_idle("c42 after w4433");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("idle after b2b");
    end

    // Drop cyc at cycle 10 of a 0x00FF transfer.
    cyc_i = 1'b1;
    dat_i = 16'h00ff;
    tick();
    run_word(eb_00ff, 1'b0, 10, "w00ff drop");
    tick();
    chk_idle("drop c42");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("drop idle");
    end

    // Reset for one edge at cycle 15 of a transfer.
    cyc_i = 1'b1;
    dat_i = 16'h2211;
    tick();
    for (int i = 1; i < 15; i++) tick();
    chk({31'd0, txc_o}, 32'd1, "c15 strobe");
    chk({31'd0, txd_o}, 32'd0, "c15 data");
    reset_i = 1'b1;
    cyc_i   = 1'b0;
    tick();
    reset_i = 1'b0;
    chk_idle("after mid reset");
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_idle("post reset idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
